// File: rtl/i2c_slave_read_responder.sv
// i2c_slave_read_responder: I2C target that answers 2-byte reads at SLAVE_ADDR.
// The returned word is latched from data_in at the address ACK and again on each
// master ACK after the LSB (continuous read). SCL/SDA are oversampled on clk_200khz.
// Optional build macro: I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchroniser (edge-to-action latency SYNC_STAGES+3 instead of +1).
module i2c_slave_read_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_200khz,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  output logic        sda_dir,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        rd_done,
  output logic        addr_hit
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, TX_MSB, M_ACK1, TX_LSB, M_ACK2, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   w_scl, w_sda;
  logic                   r_scl_prev, r_sda_prev;

  // Input synchronisers; idle-high bus level on reset
  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_f, r_sda_f;
  logic       w_scl_s, w_sda_s;
  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

  // Majority of the last three synced samples; a lone odd sample never wins
  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], w_scl_s};
      r_sda_hist <= {r_sda_hist[0], w_sda_s};
      r_scl_f    <= (w_scl_s & r_scl_hist[0]) | (w_scl_s & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_f    <= (w_sda_s & r_sda_hist[0]) | (w_sda_s & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end
  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif

  // Previous conditioned levels for edge detection
  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & ~r_sda_prev & w_sda;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_sh, w_sh_nxt;
  logic [15:0] r_shadow, w_shadow_nxt;
  logic        r_sda_dir, w_sda_dir_nxt;
  logic        r_out_bit, w_out_bit_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_acked, w_acked_nxt;
  logic        r_rd_done, w_rd_done_nxt;
  logic        r_addr_hit, w_addr_hit_nxt;

  // State and datapath registers; reset releases SDA in the same cycle
  always_ff @(posedge clk_200khz) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_shadow   <= '0;
      r_sda_dir  <= 1'b0;
      r_out_bit  <= 1'b1;
      r_busy     <= 1'b0;
      r_acked    <= 1'b0;
      r_rd_done  <= 1'b0;
      r_addr_hit <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sh       <= w_sh_nxt;
      r_shadow   <= w_shadow_nxt;
      r_sda_dir  <= w_sda_dir_nxt;
      r_out_bit  <= w_out_bit_nxt;
      r_busy     <= w_busy_nxt;
      r_acked    <= w_acked_nxt;
      r_rd_done  <= w_rd_done_nxt;
      r_addr_hit <= w_addr_hit_nxt;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  // Data bits change on SCL fall only, so SDA never moves while SCL is high.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sh_nxt       = r_sh;
    w_shadow_nxt   = r_shadow;
    w_sda_dir_nxt  = r_sda_dir;
    w_out_bit_nxt  = r_out_bit;
    w_busy_nxt     = r_busy;
    w_acked_nxt    = r_acked;
    w_rd_done_nxt  = 1'b0;
    w_addr_hit_nxt = 1'b0;
    if (w_stop) begin
      w_state_nxt   = IDLE;
      w_sda_dir_nxt = 1'b0;
      w_out_bit_nxt = 1'b1;
      w_busy_nxt    = 1'b0;
      w_acked_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_cnt_nxt     = '0;
      w_sda_dir_nxt = 1'b0;
      w_out_bit_nxt = 1'b1;
      w_acked_nxt   = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_scl_rise) begin
          w_sh_nxt  = {r_sh[6:0], w_sda};
          w_cnt_nxt = r_cnt + 4'd1;
          if (r_cnt == 4'd7) begin
            w_state_nxt = ADDR_ACK;
            w_cnt_nxt   = '0;
            w_acked_nxt = 1'b0;
          end
        end
        ADDR_ACK: if (w_scl_fall) begin
          if (r_acked) begin
            // End of our ACK bit: present the first data bit right away
            w_state_nxt   = TX_MSB;
            w_out_bit_nxt = r_shadow[15];
            w_sda_dir_nxt = 1'b1;
            w_cnt_nxt     = 4'd1;
          end else if (r_sh[7:1] == SLAVE_ADDR && r_sh[0]) begin
            w_sda_dir_nxt  = 1'b1;
            w_out_bit_nxt  = 1'b0;
            w_shadow_nxt   = data_in;
            w_addr_hit_nxt = 1'b1;
            w_busy_nxt     = 1'b1;
            w_acked_nxt    = 1'b1;
          end else begin
            w_state_nxt = WAIT_STOP;
          end
        end
        TX_MSB, TX_LSB: if (w_scl_fall) begin
          if (r_cnt == 4'd8) begin
            w_sda_dir_nxt = 1'b0;
            w_out_bit_nxt = 1'b1;
            w_state_nxt   = (r_state == TX_MSB) ? M_ACK1 : M_ACK2;
          end else begin
            // Index 15-cnt for the MSB byte, 7-cnt for the LSB byte
            w_out_bit_nxt = r_shadow[{r_state == TX_MSB, ~r_cnt[2:0]}];
            w_sda_dir_nxt = 1'b1;
            w_cnt_nxt     = r_cnt + 4'd1;
          end
        end
        M_ACK1: if (w_scl_rise) begin
          w_state_nxt = w_sda ? WAIT_STOP : TX_LSB;
          w_cnt_nxt   = '0;
        end
        M_ACK2: if (w_scl_rise) begin
          w_cnt_nxt = '0;
          if (w_sda) begin
            w_rd_done_nxt = 1'b1;
            w_state_nxt   = WAIT_STOP;
          end else begin
            w_shadow_nxt = data_in;
            w_state_nxt  = TX_MSB;
          end
        end
        WAIT_STOP: w_sda_dir_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda      = (r_sda_dir && !r_out_bit) ? 1'b0 : 1'bz;
  assign sda_dir  = r_sda_dir;
  assign busy     = r_busy;
  assign rd_done  = r_rd_done;
  assign addr_hit = r_addr_hit;

endmodule

// File: tb/tb_i2c_slave_read_responder.sv
// Bench for i2c_slave_read_responder: bit-banged I2C master, table of directed
// reads, randomized reads checked against a transaction-level model, plus
// hand-written repeated-START, reset-mid-transfer and SDA-glitch sequences.
module tb_i2c_slave_read_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] data_in = '0;
  logic        sda_dir, busy, rd_done, addr_hit;
  wire         sda;

  always #5 clk = ~clk;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave_read_responder dut (
    .clk_200khz(clk), .rst(rst), .scl(scl), .sda(sda), .sda_dir(sda_dir),
    .data_in(data_in), .busy(busy), .rd_done(rd_done), .addr_hit(addr_hit)
  );

  int n_cmp = 0, n_bad = 0;
  int hit_cnt = 0, rd_cnt = 0, dir_cnt = 0, viol = 0;
  logic scl_q = 1'b1, sda_q = 1'b1, mrel_q = 1'b1;
  logic [15:0] wq [4];

  // Event counters and a check that nobody but the master moves SDA while SCL is high
  always @(posedge clk) begin
    if (addr_hit) hit_cnt++;
    if (rd_done)  rd_cnt++;
    if (sda_dir)  dir_cnt++;
    if (scl_q && scl && mrel_q && m_sda && sda !== sda_q) viol++;
    scl_q  = scl;
    sda_q  = sda;
    mrel_q = m_sda;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    wait_cyc(5); m_sda = b;
    wait_cyc(5); scl = 1'b1;
    wait_cyc(5); r = sda;
    wait_cyc(5); scl = 1'b0;
  endtask

  task automatic start_c;
    m_sda = 1'b1; wait_cyc(5);
    scl = 1'b1;   wait_cyc(5);
    m_sda = 1'b0; wait_cyc(5);
    scl = 1'b0;
  endtask

  task automatic stop_c;
    wait_cyc(5); m_sda = 1'b0;
    wait_cyc(5); scl = 1'b1;
    wait_cyc(5); m_sda = 1'b1;
    wait_cyc(10);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic r;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, r);
      v = {v[6:0], r};
    end
  endtask

  // Transaction-level reference: ACK only for a read to 0x68
  function automatic logic model_ack(input logic [7:0] a);
    return (a[7:1] == 7'h68) && a[0];
  endfunction

  // mode 0: normal, 1: NACK after MSB, 2: repeated START after MSB, 3: rst mid-LSB
  task automatic do_read(input logic [7:0] addr, input int nwords, input int mode,
                         input logic exp_ack, input int exp_hits, input int exp_rd);
    int h0, r0, d0, d1;
    logic a;
    logic [7:0] b;
    h0 = hit_cnt; r0 = rd_cnt; d0 = dir_cnt;
    data_in = wq[0];
    start_c;
    for (int i = 7; i >= 0; i--) bit_io(addr[i], a);
    bit_io(1'b1, a);
    chk("addr_ack", {31'd0, a}, {31'd0, ~exp_ack});
    data_in = 16'($urandom);
    if (exp_ack) begin
      for (int k = 0; k < nwords; k++) begin
        read_byte(b);
        chk("msb_byte", {24'd0, b}, {24'd0, wq[k][15:8]});
        if (mode == 1) begin bit_io(1'b1, a); break; end
        if (mode == 2) begin
          start_c;
          wait_cyc(5);
          chk("rs_released", {31'd0, sda_dir}, 32'd0);
          chk("rs_busy", {31'd0, busy}, 32'd1);
          chk("rs_hits", hit_cnt - h0, exp_hits);
          chk("rs_rd_done", rd_cnt - r0, exp_rd);
          return;
        end
        bit_io(1'b0, a);
        if (mode == 3) begin
          for (int i = 0; i < 3; i++) bit_io(1'b1, a);
          wait_cyc(5);
          rst = 1'b1;
          @(posedge clk); #1;
          chk("rst_sda_dir", {31'd0, sda_dir}, 32'd0);
          chk("rst_busy", {31'd0, busy}, 32'd0);
          @(negedge clk) rst = 1'b0;
          d1 = dir_cnt;
          for (int i = 0; i < 6; i++) bit_io(1'b1, a);
          chk("rst_bus_ignored", dir_cnt - d1, 32'd0);
          break;
        end
        read_byte(b);
        chk("lsb_byte", {24'd0, b}, {24'd0, wq[k][7:0]});
        if (k == nwords - 1) bit_io(1'b1, a);
        else begin
          data_in = wq[k+1];
          bit_io(1'b0, a);
          data_in = 16'($urandom);
        end
      end
    end else begin
      read_byte(b);
      chk("nack_no_drive", {24'd0, b}, 32'hFF);
    end
    stop_c;
    chk("hits", hit_cnt - h0, exp_hits);
    chk("rd_done", rd_cnt - r0, exp_rd);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    if (!exp_ack) chk("dir_never", dir_cnt - d0, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] w0, w1;
    int          nw, mode;
    logic        exp_ack;
    int          exp_hits, exp_rd;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [7:0] ra, ga;
    logic a;
    int nw, md, h0;
    tbl[0] = '{8'hD1, 16'hBEEF, 16'h0000, 1, 0, 1'b1, 1, 1};
    tbl[1] = '{8'hD3, 16'hBEEF, 16'h0000, 1, 0, 1'b0, 0, 0};
    tbl[2] = '{8'hD0, 16'hBEEF, 16'h0000, 1, 0, 1'b0, 0, 0};
    tbl[3] = '{8'hD1, 16'h1234, 16'h5678, 2, 0, 1'b1, 1, 1};
    tbl[4] = '{8'hD1, 16'hA55A, 16'h0000, 1, 1, 1'b1, 1, 0};
    tbl[5] = '{8'hD1, 16'hC3C3, 16'h0000, 1, 3, 1'b1, 1, 0};

    // Reset state
    wait_cyc(4);
    chk("rst_sda_dir0", {31'd0, sda_dir}, 32'd0);
    chk("rst_busy0", {31'd0, busy}, 32'd0);
    chk("rst_rd_done0", {31'd0, rd_done}, 32'd0);
    chk("rst_addr_hit0", {31'd0, addr_hit}, 32'd0);
    chk("rst_sda_released", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    wait_cyc(10);

    // Directed table
    for (int t = 0; t < 6; t++) begin
      wq[0] = tbl[t].w0; wq[1] = tbl[t].w1;
      do_read(tbl[t].addr, tbl[t].nw, tbl[t].mode, tbl[t].exp_ack,
              tbl[t].exp_hits, tbl[t].exp_rd);
      wait_cyc(10);
    end

    // Repeated START after MSB, then a fresh read returns the new data_in
    wq[0] = 16'h1111;
    do_read(8'hD1, 1, 2, 1'b1, 1, 0);
    wq[0] = 16'h2222;
    do_read(8'hD1, 1, 0, 1'b1, 1, 1);
    wait_cyc(10);

    // Randomized reads against the transaction model
    for (int t = 0; t < 16; t++) begin
      ra = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hD1;
      nw = $urandom_range(3, 1);
      md = ($urandom_range(4) == 0) ? 1 : 0;
      for (int k = 0; k < 4; k++) wq[k] = 16'($urandom);
      do_read(ra, nw, md, model_ack(ra), model_ack(ra) ? 1 : 0,
              (model_ack(ra) && md == 0) ? 1 : 0);
      wait_cyc(10);
    end

    // One-cycle SDA low pulse while SCL is high, inside the first address bit
    ga = 8'hD1;
    h0 = hit_cnt;
    start_c;
    wait_cyc(5); m_sda = 1'b1;
    wait_cyc(5); scl = 1'b1;
    wait_cyc(3); m_sda = 1'b0;
    wait_cyc(1); m_sda = 1'b1;
    wait_cyc(6); scl = 1'b0;
    for (int i = 6; i >= 0; i--) bit_io(ga[i], a);
    bit_io(1'b1, a);
`ifdef I2C_SLV_GLITCH_FILTER_EN
    chk("glitch_filtered_ack", {31'd0, a}, 32'd0);
    chk("glitch_filtered_hits", hit_cnt - h0, 32'd1);
`else
    chk("glitch_decoded_nack", {31'd0, a}, 32'd1);
    chk("glitch_decoded_hits", hit_cnt - h0, 32'd0);
`endif
    stop_c;
    chk("glitch_busy", {31'd0, busy}, 32'd0);

    chk("sda_stable_scl_high", viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
